// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle MIPS-subset control FSM (IF/ID/EXE/MEM/WB/HALTED)
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWre,
  output logic       IRWre,
  output logic [1:0] PCSrc,
  output logic [1:0] ExtSel,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegDst,
  output logic       RegWre,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [2:0] state,
  output logic       Halted,
  output logic       Illegal
);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE    = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALTED = 3'b101
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [5:0]    op_q;
  logic [CW-1:0] wait_q, wait_d;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_IF;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_ID) op_q <= op;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    PCSrc     = 2'b00;
    ExtSel    = 2'b00;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    RegDst    = 1'b0;
    RegWre    = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    Halted    = 1'b0;
    Illegal   = 1'b0;
    state     = state_q;

    // ALU controls stay on from EXE through MEM/WB so the result is stable
    if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
      case (op_q)
        OP_SUB:              ALUOp = 3'b001;
        OP_ADDI, OP_SW, OP_LW: begin ALUSrcB = 1'b1; ExtSel = 2'b10; end
        OP_ORI:  begin ALUOp = 3'b011; ALUSrcB = 1'b1; ExtSel = 2'b01; end
        OP_SLL:  begin ALUOp = 3'b100; ALUSrcB = 1'b1; ExtSel = 2'b00; end
        OP_BEQ:  begin ALUOp = 3'b001; ExtSel = 2'b10; end
        default: ;
      endcase
    end

    case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        case (op)
          OP_J: begin
            PCWre   = 1'b1;
            PCSrc   = 2'b10;
            state_d = S_IF;
          end
          OP_HALT: state_d = S_HALTED;
          OP_ADD, OP_SUB, OP_ADDI, OP_ORI, OP_SLL,
          OP_SW, OP_LW, OP_BEQ: state_d = S_EXE;
          default: begin
            Illegal = 1'b1;
            PCWre   = 1'b1;
            state_d = S_IF;
          end
        endcase
      end
      S_EXE: begin
        if (op_q == OP_BEQ) begin
          PCWre   = 1'b1;
          PCSrc   = zero ? 2'b01 : 2'b00;
          state_d = S_IF;
        end else if (op_q == OP_SW || op_q == OP_LW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mWR = (op_q == OP_SW);
        mRD = (op_q == OP_LW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            PCWre   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d = S_HALTED;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        RegWre    = 1'b1;
        PCWre     = 1'b1;
        RegDst    = (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_SLL);
        DBDataSrc = (op_q == OP_LW);
        state_d   = S_IF;
      end
      S_HALTED: Halted = 1'b1;
      default:  state_d = S_IF;
    endcase

    // While reset is held every output reads as zero
    if (!Reset) begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      PCSrc     = 2'b00;
      ExtSel    = 2'b00;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'b000;
      RegDst    = 1'b0;
      RegWre    = 1'b0;
      DBDataSrc = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      Halted    = 1'b0;
      Illegal   = 1'b0;
      state     = 3'b000;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef struct packed {
    logic [2:0] state;
    logic       PCWre;
    logic       IRWre;
    logic [1:0] PCSrc;
    logic [1:0] ExtSel;
    logic       ALUSrcB;
    logic [2:0] ALUOp;
    logic       RegDst;
    logic       RegWre;
    logic       DBDataSrc;
    logic       mRD;
    logic       mWR;
    logic       Halted;
    logic       Illegal;
  } out_t;

  typedef struct packed {
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    out_t       o;
  } cyc_t;

  logic CLK = 1'b0;
  logic Reset;
  logic [5:0] op;
  logic zero, mem_ready;
  logic PCWre, IRWre, ALUSrcB, RegDst, RegWre, DBDataSrc, mRD, mWR, Halted, Illegal;
  logic [1:0] PCSrc, ExtSel;
  logic [2:0] ALUOp, state;

  int errors = 0;
  int checks = 0;
  cyc_t exp_q[$];

  always #5 CLK = ~CLK;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc), .ExtSel(ExtSel), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .RegDst(RegDst), .RegWre(RegWre), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .state(state), .Halted(Halted), .Illegal(Illegal)
  );

  function automatic out_t sample();
    out_t s;
    s.state = state; s.PCWre = PCWre; s.IRWre = IRWre; s.PCSrc = PCSrc;
    s.ExtSel = ExtSel; s.ALUSrcB = ALUSrcB; s.ALUOp = ALUOp; s.RegDst = RegDst;
    s.RegWre = RegWre; s.DBDataSrc = DBDataSrc; s.mRD = mRD; s.mWR = mWR;
    s.Halted = Halted; s.Illegal = Illegal;
    return s;
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {OP_ADD, OP_SUB, OP_ADDI, OP_ORI, OP_SLL, OP_SW, OP_LW, OP_BEQ, OP_J, OP_HALT};
  endfunction

  // Cycle with don't-care inputs randomized and all outputs low
  function automatic cyc_t rnd_cyc();
    cyc_t c;
    c = '0;
    c.rst_n = 1'b1;
    c.op = 6'($urandom);
    c.zero = 1'($urandom);
    c.mem_ready = 1'($urandom);
    return c;
  endfunction

  task automatic model_reset();
    cyc_t c;
    c = rnd_cyc();
    c.rst_n = 1'b0;
    exp_q.push_back(c);
  endtask

  task automatic model_halted(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = rnd_cyc();
      c.o.state = 3'd5;
      c.o.Halted = 1'b1;
      exp_q.push_back(c);
    end
  endtask

  // Expected trace of one instruction, stage by stage, from the instruction set rules
  task automatic model_instr(input logic [5:0] opc, input logic z, input int waits);
    cyc_t c;
    out_t alu;
    c = rnd_cyc();
    c.o.IRWre = 1'b1;
    exp_q.push_back(c);
    c = rnd_cyc();
    c.op = opc;
    c.o.state = 3'd1;
    if (opc == OP_J) begin
      c.o.PCWre = 1'b1; c.o.PCSrc = 2'b10; exp_q.push_back(c); return;
    end
    if (opc == OP_HALT) begin exp_q.push_back(c); return; end
    if (!is_legal(opc)) begin
      c.o.Illegal = 1'b1; c.o.PCWre = 1'b1; exp_q.push_back(c); return;
    end
    exp_q.push_back(c);
    alu = '0;
    case (opc)
      OP_ADD:  begin alu.ALUOp = 3'b000; alu.ALUSrcB = 1'b0; end
      OP_SUB:  begin alu.ALUOp = 3'b001; alu.ALUSrcB = 1'b0; end
      OP_ORI:  begin alu.ALUOp = 3'b011; alu.ALUSrcB = 1'b1; alu.ExtSel = 2'b01; end
      OP_SLL:  begin alu.ALUOp = 3'b100; alu.ALUSrcB = 1'b1; alu.ExtSel = 2'b00; end
      OP_BEQ:  begin alu.ALUOp = 3'b001; alu.ALUSrcB = 1'b0; alu.ExtSel = 2'b10; end
      default: begin alu.ALUOp = 3'b000; alu.ALUSrcB = 1'b1; alu.ExtSel = 2'b10; end
    endcase
    c = rnd_cyc();
    c.o = alu;
    c.o.state = 3'd2;
    if (opc == OP_BEQ) begin
      c.zero = z; c.o.PCWre = 1'b1; c.o.PCSrc = z ? 2'b01 : 2'b00;
      exp_q.push_back(c); return;
    end
    exp_q.push_back(c);
    if (opc == OP_SW || opc == OP_LW) begin
      for (int i = 0; i < waits && i < 15; i++) begin
        c = rnd_cyc();
        c.mem_ready = 1'b0;
        c.o = alu; c.o.state = 3'd3;
        c.o.mRD = (opc == OP_LW); c.o.mWR = (opc == OP_SW);
        exp_q.push_back(c);
      end
      if (waits >= 15) return;
      c = rnd_cyc();
      c.mem_ready = 1'b1;
      c.o = alu; c.o.state = 3'd3;
      c.o.mRD = (opc == OP_LW); c.o.mWR = (opc == OP_SW);
      c.o.PCWre = (opc == OP_SW);
      exp_q.push_back(c);
      if (opc == OP_SW) return;
    end
    c = rnd_cyc();
    c.o = alu; c.o.state = 3'd4;
    c.o.RegWre = 1'b1; c.o.PCWre = 1'b1;
    c.o.RegDst = (opc == OP_ADD || opc == OP_SUB || opc == OP_SLL);
    c.o.DBDataSrc = (opc == OP_LW);
    exp_q.push_back(c);
  endtask

  task automatic drive_cycle(input cyc_t c, output out_t obs);
    Reset = c.rst_n; op = c.op; zero = c.zero; mem_ready = c.mem_ready;
    @(negedge CLK);
    obs = sample();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    out_t obs;
    exp_q.delete();
    model_reset(); model_reset();
    model_instr(OP_ADD, 1'b0, 0);
    foreach (exp_q[i]) begin
      drive_cycle(exp_q[i], obs);
      checks++;
      if (obs !== exp_q[i].o) begin
        errors++; $display("FAIL reset cyc%0d got=%h want=%h", i, obs, exp_q[i].o);
      end
    end
  endtask

  task automatic test_alu_ops();
    out_t obs;
    exp_q.delete();
    model_instr(OP_ADDI, 1'b0, 0);
    model_instr(OP_SLL, 1'b0, 0);
    model_instr(OP_ORI, 1'b0, 0);
    model_instr(OP_SUB, 1'b1, 0);
    foreach (exp_q[i]) begin
      drive_cycle(exp_q[i], obs);
      checks++;
      if (obs !== exp_q[i].o) begin
        errors++; $display("FAIL alu_ops cyc%0d got=%h want=%h", i, obs, exp_q[i].o);
      end
    end
  endtask

  task automatic test_lw_wait();
    out_t obs;
    exp_q.delete();
    model_instr(OP_LW, 1'b0, 3);
    model_instr(OP_SW, 1'b0, 0);
    model_instr(OP_SW, 1'b0, 2);
    foreach (exp_q[i]) begin
      drive_cycle(exp_q[i], obs);
      checks++;
      if (obs !== exp_q[i].o) begin
        errors++; $display("FAIL lw_wait cyc%0d got=%h want=%h", i, obs, exp_q[i].o);
      end
    end
  endtask

  task automatic test_beq();
    out_t obs;
    exp_q.delete();
    model_instr(OP_BEQ, 1'b1, 0);
    model_instr(OP_BEQ, 1'b0, 0);
    model_instr(OP_J, 1'b0, 0);
    foreach (exp_q[i]) begin
      drive_cycle(exp_q[i], obs);
      checks++;
      if (obs !== exp_q[i].o) begin
        errors++; $display("FAIL beq cyc%0d got=%h want=%h", i, obs, exp_q[i].o);
      end
    end
  endtask

  task automatic test_illegal_halt();
    out_t obs;
    exp_q.delete();
    model_instr(6'b101010, 1'b0, 0);
    model_instr(OP_HALT, 1'b0, 0);
    model_halted(20);
    model_reset();
    model_instr(OP_ADDI, 1'b0, 0);
    foreach (exp_q[i]) begin
      drive_cycle(exp_q[i], obs);
      checks++;
      if (obs !== exp_q[i].o) begin
        errors++; $display("FAIL illegal_halt cyc%0d got=%h want=%h", i, obs, exp_q[i].o);
      end
    end
  endtask

  task automatic test_sw_timeout();
    out_t obs;
    exp_q.delete();
    model_instr(OP_SW, 1'b0, 15);
    model_halted(6);
    model_reset();
    model_instr(OP_LW, 1'b0, 14);
    foreach (exp_q[i]) begin
      drive_cycle(exp_q[i], obs);
      checks++;
      if (obs !== exp_q[i].o) begin
        errors++; $display("FAIL sw_timeout cyc%0d got=%h want=%h", i, obs, exp_q[i].o);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    out_t obs;
    exp_q.delete();
    model_instr(OP_LW, 1'b0, 5);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    model_reset();
    exp_q[5].mem_ready = 1'b1;
    model_instr(OP_ADD, 1'b0, 0);
    foreach (exp_q[i]) begin
      drive_cycle(exp_q[i], obs);
      checks++;
      if (obs !== exp_q[i].o) begin
        errors++; $display("FAIL reset_mid_mem cyc%0d got=%h want=%h", i, obs, exp_q[i].o);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_t obs;
    logic [5:0] pick;
    logic [5:0] ops [10];
    ops = '{OP_ADD, OP_SUB, OP_ADDI, OP_ORI, OP_SLL, OP_SW, OP_LW, OP_BEQ, OP_J, 6'b0};
    exp_q.delete();
    for (int n = 0; n < 60; n++) begin
      pick = ops[$urandom_range(9)];
      if (n % 10 == 9) begin
        do pick = 6'($urandom); while (is_legal(pick));
      end
      model_instr(pick, 1'($urandom), int'($urandom_range(4)));
    end
    foreach (exp_q[i]) begin
      drive_cycle(exp_q[i], obs);
      checks++;
      if (obs !== exp_q[i].o) begin
        errors++; $display("FAIL back_to_back cyc%0d got=%h want=%h", i, obs, exp_q[i].o);
      end
    end
  endtask

  initial begin
    Reset = 1'b0; op = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_alu_ops();
    test_lw_wait();
    test_beq();
    test_illegal_halt();
    test_sw_timeout();
    test_reset_mid_mem();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
